// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizer/filter bank: stage limits, counter
// sizing helper and the per-channel debounce state record.
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int DEB_CNT_MAX_W   = 8;

    // Bits needed to represent v distinct values.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // The counter field is wide enough for any legal DEB_W; only the low
    // DEB_W bits are ever non-zero.
    typedef struct packed {
        logic [DEB_CNT_MAX_W-1:0] cnt;
        logic                     filt;
    } deb_state_t;

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
module sync_chain
    import sync_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end

    logic [STAGES-1:0] stg_q;
    logic [STAGES-1:0] stg_d;

    // Shift the sampled input one stage deeper each cycle.
    always_comb begin
        stg_d = {stg_q[STAGES-2:0], d};
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= {STAGES{1'b0}};
        end else begin
            stg_q <= stg_d;
        end
    end

    assign q = stg_q[STAGES-1];

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: synchronize, debounce and edge-detect CH
// level inputs, and capture a source-held bus once per rising qualifier edge.
module sync_filter_bank
    import sync_pkg::*;
#(
    parameter int CH      = 4,
    parameter int STAGES  = 2,
    parameter int DEB_W   = 3,
    parameter int DEB_CNT = 4,
    parameter int DW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] async_in,
    input  logic [DW-1:0] bus_in,
    input  logic          bus_en,
    output logic [CH-1:0] sync_out,
    output logic [CH-1:0] filt_out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [DW-1:0] bus_out,
    output logic          bus_vld
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_filter_bank: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if (DEB_W < 1 || DEB_W > DEB_CNT_MAX_W) begin : g_bad_deb_w
        $error("sync_filter_bank: DEB_W out of range");
    end
    if (DEB_CNT < 1 || clog2(DEB_CNT + 1) > DEB_W) begin : g_bad_deb_cnt
        $error("sync_filter_bank: DEB_CNT must be in 1..2**DEB_W-1");
    end
    if (CH < 1 || DW < 1) begin : g_bad_width
        $error("sync_filter_bank: CH and DW must be positive");
    end

    localparam logic [DEB_CNT_MAX_W-1:0] CNT_LAST = DEB_CNT_MAX_W'(DEB_CNT - 1);

    logic [CH-1:0] sync_s;
    logic          en_sync_s;

    for (genvar i = 0; i < CH; i++) begin : g_ch_sync
        sync_chain #(.STAGES(STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (async_in[i]),
            .q   (sync_s[i])
        );
    end

    sync_chain #(.STAGES(STAGES)) u_en_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus_en),
        .q   (en_sync_s)
    );

    deb_state_t    deb_q [CH];
    deb_state_t    deb_d [CH];
    logic [CH-1:0] rise_q, rise_d;
    logic [CH-1:0] fall_q, fall_d;
    logic          en_prev_q, en_prev_d;
    logic [DW-1:0] bus_q, bus_d;
    logic          vld_q, vld_d;

    // Debounce: a disagreement must persist DEB_CNT cycles before the
    // filtered level follows; any agreement restarts qualification.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            deb_d[i]  = deb_q[i];
            rise_d[i] = 1'b0;
            fall_d[i] = 1'b0;
            if (sync_s[i] == deb_q[i].filt) begin
                deb_d[i].cnt = {DEB_CNT_MAX_W{1'b0}};
            end else if (deb_q[i].cnt == CNT_LAST) begin
                deb_d[i].cnt  = {DEB_CNT_MAX_W{1'b0}};
                deb_d[i].filt = sync_s[i];
                rise_d[i]     = sync_s[i];
                fall_d[i]     = ~sync_s[i];
            end else begin
                deb_d[i].cnt = DEB_CNT_MAX_W'(deb_q[i].cnt[DEB_W-1:0] + {{(DEB_W-1){1'b0}}, 1'b1});
            end
        end
    end

    // Bus capture on the rising edge of the synchronized qualifier only.
    always_comb begin
        en_prev_d = en_sync_s;
        vld_d     = en_sync_s & ~en_prev_q;
        if (vld_d) begin
            bus_d = bus_in;
        end else begin
            bus_d = bus_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                deb_q[i] <= '{cnt: {DEB_CNT_MAX_W{1'b0}}, filt: 1'b0};
            end
            rise_q    <= {CH{1'b0}};
            fall_q    <= {CH{1'b0}};
            en_prev_q <= 1'b0;
            bus_q     <= {DW{1'b0}};
            vld_q     <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                deb_q[i] <= deb_d[i];
            end
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            en_prev_q <= en_prev_d;
            bus_q     <= bus_d;
            vld_q     <= vld_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            filt_out[i] = deb_q[i].filt;
        end
    end

    assign sync_out = sync_s;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign bus_out  = bus_q;
    assign bus_vld  = vld_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Randomized and directed bench for sync_filter_bank, two parameterisations
// checked against a cycle-level behavioural model.
module tb_sync_filter_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] async_in = 4'h0;
    logic [3:0] bus_in = 4'h0;
    logic       bus_en = 1'b0;

    logic [3:0] a_sync, a_filt, a_rise, a_fall, a_bus;
    logic       a_vld;
    logic [3:0] b_sync, b_filt, b_rise, b_fall, b_bus;
    logic       b_vld;

    int n_checks = 0;
    int n_fail   = 0;
    int rise0_seen = 0;
    int vld_seen   = 0;

    always #5 clk = ~clk;

    sync_filter_bank #(.CH(4), .STAGES(2), .DEB_W(3), .DEB_CNT(4), .DW(4)) dut_a (
        .clk(clk), .rst(rst), .async_in(async_in), .bus_in(bus_in), .bus_en(bus_en),
        .sync_out(a_sync), .filt_out(a_filt), .rise(a_rise), .fall(a_fall),
        .bus_out(a_bus), .bus_vld(a_vld)
    );

    sync_filter_bank #(.CH(4), .STAGES(3), .DEB_W(3), .DEB_CNT(1), .DW(4)) dut_b (
        .clk(clk), .rst(rst), .async_in(async_in), .bus_in(bus_in), .bus_en(bus_en),
        .sync_out(b_sync), .filt_out(b_filt), .rise(b_rise), .fall(b_fall),
        .bus_out(b_bus), .bus_vld(b_vld)
    );

    // Model state, indexed by instance: the input as seen some edges ago,
    // the filtered level and how long the delayed input has disagreed with it.
    logic [3:0] m_hist  [2][8];
    logic       m_ehist [2][8];
    logic       m_eprev [2];
    logic [3:0] m_filt  [2];
    logic [3:0] m_rise  [2];
    logic [3:0] m_fall  [2];
    logic [3:0] m_bus   [2];
    logic       m_vld   [2];
    int         m_run   [2][4];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input int k, input int st, input int dc);
        logic [3:0] old_sync;
        logic       old_en;
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                m_hist[k][s]  = 4'h0;
                m_ehist[k][s] = 1'b0;
            end
            for (int c = 0; c < 4; c++) m_run[k][c] = 0;
            m_eprev[k] = 1'b0;
            m_filt[k]  = 4'h0;
            m_rise[k]  = 4'h0;
            m_fall[k]  = 4'h0;
            m_bus[k]   = 4'h0;
            m_vld[k]   = 1'b0;
        end else begin
            old_sync  = m_hist[k][st-1];
            old_en    = m_ehist[k][st-1];
            m_rise[k] = 4'h0;
            m_fall[k] = 4'h0;
            for (int c = 0; c < 4; c++) begin
                if (old_sync[c] == m_filt[k][c]) begin
                    m_run[k][c] = 0;
                end else begin
                    m_run[k][c]++;
                    if (m_run[k][c] == dc) begin
                        m_filt[k][c] = old_sync[c];
                        if (old_sync[c]) m_rise[k][c] = 1'b1;
                        else             m_fall[k][c] = 1'b1;
                        m_run[k][c] = 0;
                    end
                end
            end
            for (int s = st - 1; s > 0; s--) begin
                m_hist[k][s]  = m_hist[k][s-1];
                m_ehist[k][s] = m_ehist[k][s-1];
            end
            m_hist[k][0]  = async_in;
            m_ehist[k][0] = bus_en;
            m_vld[k]      = old_en & ~m_eprev[k];
            if (m_vld[k]) m_bus[k] = bus_in;
            m_eprev[k] = old_en;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, 2, 4);
        model_edge(1, 3, 1);
        #1;
        check_val("a_sync", 32'(a_sync), 32'(m_hist[0][1]));
        check_val("a_filt", 32'(a_filt), 32'(m_filt[0]));
        check_val("a_rise", 32'(a_rise), 32'(m_rise[0]));
        check_val("a_fall", 32'(a_fall), 32'(m_fall[0]));
        check_val("a_bus",  32'(a_bus),  32'(m_bus[0]));
        check_val("a_vld",  32'(a_vld),  32'(m_vld[0]));
        check_val("a_excl", 32'(a_rise & a_fall), 32'd0);
        check_val("b_sync", 32'(b_sync), 32'(m_hist[1][2]));
        check_val("b_filt", 32'(b_filt), 32'(m_filt[1]));
        check_val("b_rise", 32'(b_rise), 32'(m_rise[1]));
        check_val("b_fall", 32'(b_fall), 32'(m_fall[1]));
        check_val("b_bus",  32'(b_bus),  32'(m_bus[1]));
        check_val("b_vld",  32'(b_vld),  32'(m_vld[1]));
        if (a_rise[0]) rise0_seen++;
        if (a_vld) vld_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic new_en;

        // Reset with all inputs high, then release.
        rst = 1'b1;
        async_in = 4'hF;
        run(3);
        check_val("rst_filt", 32'(a_filt), 32'd0);
        rst = 1'b0;
        run(10);
        check_val("t1_filt", 32'(a_filt), 32'hF);

        // Short glitch on channel 0 must be filtered out.
        async_in = 4'h0;
        run(12);
        rise0_seen = 0;
        async_in = 4'h1;
        run(3);
        async_in = 4'h0;
        run(10);
        check_val("t2_norise", 32'(rise0_seen), 32'd0);
        check_val("t2_filt", 32'(a_filt), 32'd0);

        // Simultaneous rise and fall on different channels.
        async_in = 4'b0100;
        run(12);
        async_in = 4'b0010;
        run(12);
        check_val("t3_filt", 32'(a_filt), 32'b0010);

        // Level-held qualifier captures once; re-arm by dropping it.
        vld_seen = 0;
        bus_in = 4'hA;
        run(1);
        bus_en = 1'b1;
        run(10);
        check_val("t4_busA", 32'(a_bus), 32'hA);
        bus_in = 4'h5;
        run(3);
        check_val("t4_hold", 32'(a_bus), 32'hA);
        bus_en = 1'b0;
        run(5);
        bus_en = 1'b1;
        run(6);
        check_val("t4_bus5", 32'(a_bus), 32'h5);
        check_val("t4_vlds", 32'(vld_seen), 32'd2);

        // Reset in the middle of qualification on channel 3.
        async_in = 4'b1010;
        run(4);
        rst = 1'b1;
        run(1);
        check_val("t5_rst", 32'(a_filt), 32'd0);
        rst = 1'b0;
        run(10);
        check_val("t5_filt", 32'(a_filt), 32'b1010);

        // Random slow-moving inputs with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(5) == 0) async_in[c] = ~async_in[c];
            end
            new_en = ($urandom_range(7) == 0) ? ~bus_en : bus_en;
            if (!bus_en && !new_en) bus_in = 4'($urandom);
            bus_en = new_en;
            rst = ($urandom_range(99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
